// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter.
//   - state_e      : arbiter FSM states
//   - REQ_CPU/DMA  : requester IDs, also the encoding of the 'last' register
//   - DefaultAw/Dw : default address / data widths
//   - is_arb_state : true in the states where a new winner may be picked
package mem_arbiter_pkg;

  localparam int unsigned DefaultAw = 16;
  localparam int unsigned DefaultDw = 16;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StGntCpu = 3'd1,
    StGntDma = 3'd2,
    StRspCpu = 3'd3,
    StRspDma = 3'd4
  } state_e;

  function automatic logic is_arb_state(state_e s);
    return (s == StIdle) || (s == StRspCpu) || (s == StRspDma);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters and the memory.
//   slave  : arbiter view (requests and mem_rdata in; acks, rdata and memory
//            command out)
//   master : requester/memory view (the mirror image)
interface mem_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
) ();

  // CPU requester
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_adr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  // DMA requester
  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_adr;
  logic [DW-1:0] dma_wdata;
  logic          dma_lock;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;

  // Memory port
  logic [AW-1:0] mem_adr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_adr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_adr, dma_wdata, dma_lock,
    output dma_ack, dma_rdata,
    output mem_adr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_adr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_adr, dma_wdata, dma_lock,
    input  dma_ack, dma_rdata,
    input  mem_adr, mem_we, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational 2-way winner select.
//   cand_cpu_i/cand_dma_i : candidates already filtered by the FSM state
//   last_i                : requester granted most recently
//   lock_i, hold_cnt_i    : DMA burst lock and consecutive locked grants so far
//   valid_o               : at least one candidate
//   winner_o              : REQ_CPU or REQ_DMA (meaningful only with valid_o)
module mem_arbiter_rr_pick
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned HW       = 3
) (
  input  logic          cand_cpu_i,
  input  logic          cand_dma_i,
  input  logic          last_i,
  input  logic          lock_i,
  input  logic [HW-1:0] hold_cnt_i,
  output logic          valid_o,
  output logic          winner_o
);

  localparam logic [HW-1:0] MaxHold = HW'(MAX_HOLD);

  always_comb begin
    valid_o  = cand_cpu_i | cand_dma_i;
    winner_o = REQ_CPU;
    if (cand_cpu_i && cand_dma_i) begin
      // A locked burst keeps the port until it has used up its hold budget.
      if (lock_i && (hold_cnt_i < MaxHold)) begin
        winner_o = REQ_DMA;
      end else begin
        winner_o = ~last_i;
      end
    end else if (cand_dma_i) begin
      winner_o = REQ_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (CPU, DMA) for a single synchronous memory port.
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous, active-low
//   bus   : mem_arbiter_if.slave -- CPU and DMA request/ack channels plus the
//           registered memory command (mem_adr/mem_we/mem_wdata) and mem_rdata
// Each access takes a grant cycle (memory sees the command) followed by a
// response cycle (ack pulses, rdata is mem_rdata passed through).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW       = DefaultAw,
  parameter int unsigned DW       = DefaultDw,
  parameter int unsigned MAX_HOLD = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] MaxHold = HW'(MAX_HOLD);

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [AW-1:0] mem_adr_q, mem_adr_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          dma_ack_q, dma_ack_d;

  logic arb_en;
  logic cand_cpu;
  logic cand_dma;
  logic pick_valid;
  logic pick_winner;
  logic grant_cpu;
  logic grant_dma;

  // The requester being acked this cycle is not re-admitted, except a locked
  // DMA burst which presents its next beat during the ack cycle.
  assign arb_en   = is_arb_state(state_q);
  assign cand_cpu = arb_en && bus.cpu_req && (state_q != StRspCpu);
  assign cand_dma = arb_en && bus.dma_req && ((state_q != StRspDma) || bus.dma_lock);

  mem_arbiter_rr_pick #(
    .MAX_HOLD(MAX_HOLD),
    .HW      (HW)
  ) u_rr_pick (
    .cand_cpu_i(cand_cpu),
    .cand_dma_i(cand_dma),
    .last_i    (last_q),
    .lock_i    (bus.dma_lock),
    .hold_cnt_i(hold_cnt_q),
    .valid_o   (pick_valid),
    .winner_o  (pick_winner)
  );

  assign grant_cpu = pick_valid && (pick_winner == REQ_CPU);
  assign grant_dma = pick_valid && (pick_winner == REQ_DMA);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    mem_adr_d   = mem_adr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;

    case (state_q)
      StGntCpu: begin
        state_d   = StRspCpu;
        mem_we_d  = 1'b0;
        cpu_ack_d = 1'b1;
      end
      StGntDma: begin
        state_d   = StRspDma;
        mem_we_d  = 1'b0;
        dma_ack_d = 1'b1;
      end
      default: begin
        // StIdle, StRspCpu, StRspDma: arbitrate.
        if (grant_cpu) begin
          state_d     = StGntCpu;
          last_d      = REQ_CPU;
          mem_adr_d   = bus.cpu_adr;
          mem_we_d    = bus.cpu_we;
          mem_wdata_d = bus.cpu_wdata;
        end else if (grant_dma) begin
          state_d     = StGntDma;
          last_d      = REQ_DMA;
          mem_adr_d   = bus.dma_adr;
          mem_we_d    = bus.dma_we;
          mem_wdata_d = bus.dma_wdata;
        end else begin
          state_d  = StIdle;
          mem_we_d = 1'b0;
        end
      end
    endcase
  end

  // Counts DMA grants taken while the CPU was waiting.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (!bus.cpu_req || grant_cpu) begin
      hold_cnt_d = '0;
    end else if (grant_dma && (hold_cnt_q != MaxHold)) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      last_q      <= REQ_DMA;
      hold_cnt_q  <= '0;
      mem_adr_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      hold_cnt_q  <= hold_cnt_d;
      mem_adr_q   <= mem_adr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
    end
  end

  assign bus.mem_adr   = mem_adr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dma_ack   = dma_ack_q;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.dma_rdata = bus.mem_rdata;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_ack_q;

endmodule
